// File: rtl/rvm_constants.sv
// Shared constants for the memory-bus arbiter: controller command codes and arbiter FSM state encoding.
package rvm_constants;

  localparam logic [2:0] MEM_CMD_WRITE = 3'b000;
  localparam logic [2:0] MEM_CMD_READ  = 3'b001;

  typedef enum logic [0:0] {
    ARB_S_ARB   = 1'b0,
    ARB_S_ISSUE = 1'b1
  } arb_state_t;

  // Only the exact write code is a write; every other code is issued as a read.
  function automatic logic is_write_cmd(input logic [2:0] cmd);
    return (cmd == MEM_CMD_WRITE);
  endfunction

endpackage

// File: rtl/mem_bus_arb_if.sv
// Request/response bundle for both arbiter ports plus the memory-controller application bus.
interface mem_bus_arb_if #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128
);
  logic                  p0_en;
  logic [2:0]            p0_cmd;
  logic [ADDR_W-1:0]     p0_addr;
  logic [DATA_W-1:0]     p0_wdata;
  logic [DATA_W/8-1:0]   p0_wmask;
  logic                  p0_rdy;
  logic                  p0_rd_valid;

  logic                  p1_en;
  logic [2:0]            p1_cmd;
  logic [ADDR_W-1:0]     p1_addr;
  logic [DATA_W-1:0]     p1_wdata;
  logic [DATA_W/8-1:0]   p1_wmask;
  logic                  p1_rdy;
  logic                  p1_rd_valid;

  logic [DATA_W-1:0]     rd_data;
  logic                  grant;
  logic                  err_orphan;

  logic [ADDR_W-1:0]     app_addr;
  logic [2:0]            app_cmd;
  logic                  app_en;
  logic [DATA_W-1:0]     app_wdf_data;
  logic [DATA_W/8-1:0]   app_wdf_mask;
  logic                  app_wdf_wren;
  logic                  app_wdf_end;
  logic                  app_rdy;
  logic                  app_wdf_rdy;
  logic [DATA_W-1:0]     app_rd_data;
  logic                  app_rd_data_valid;

  // Requesters and memory controller together.
  modport master (
    output p0_en, p0_cmd, p0_addr, p0_wdata, p0_wmask,
    output p1_en, p1_cmd, p1_addr, p1_wdata, p1_wmask,
    output app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid,
    input  p0_rdy, p0_rd_valid, p1_rdy, p1_rd_valid, rd_data, grant, err_orphan,
    input  app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end
  );

  // The arbiter.
  modport slave (
    input  p0_en, p0_cmd, p0_addr, p0_wdata, p0_wmask,
    input  p1_en, p1_cmd, p1_addr, p1_wdata, p1_wmask,
    input  app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid,
    output p0_rdy, p0_rd_valid, p1_rdy, p1_rd_valid, rd_data, grant, err_orphan,
    output app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end
  );
endinterface

// File: rtl/mem_arb_tag_fifo.sv
// In-order FIFO of 1-bit port tags for outstanding reads; head is visible combinationally.
module mem_arb_tag_fifo #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic resetn,
  input  logic i_push,
  input  logic i_din,
  input  logic i_pop,
  output logic o_full,
  output logic o_empty,
  output logic o_head
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [DEPTH-1:0] r_mem;
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  // A full FIFO still takes a push when the same cycle frees a slot.
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == {(AW+1){1'b0}});
  assign o_head  = r_mem[r_rd_ptr];

  // Tag storage; contents need no reset because the count gates every read.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  // Pointers and occupancy count.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {(AW+1){1'b0}};
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/mem_bus_arb.sv
// Two-port round-robin arbiter for the memory-controller application bus with in-order read steering.
// Optional MEM_ARB_LOCK_EN adds input bus_owner, which restricts arbitration to the owning port.
module mem_bus_arb
  import rvm_constants::*;
#(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128,
  parameter int OUTST  = 4
) (
  input logic clk,
  input logic resetn,
`ifdef MEM_ARB_LOCK_EN
  input logic bus_owner,
`endif
  mem_bus_arb_if.slave bus
);
  localparam int MASK_W = DATA_W / 8;

  arb_state_t        r_state;
  logic              r_grant;
  logic              r_ptr;
  logic              r_err_orphan;

  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic              w_fifo_head;
  logic              w_own0;
  logic              w_own1;
  logic              w_p0_elig;
  logic              w_p1_elig;
  logic              w_any_elig;
  logic              w_winner;
  logic [2:0]        w_sel_cmd;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;
  logic [MASK_W-1:0] w_sel_wmask;
  logic              w_sel_write;
  logic              w_issue;
  logic              w_accept;
  logic              w_push;
  logic              w_pop;

`ifdef MEM_ARB_LOCK_EN
  assign w_own0 = ~bus_owner;
  assign w_own1 = bus_owner;
`else
  assign w_own0 = 1'b1;
  assign w_own1 = 1'b1;
`endif

  // Eligibility and winner choice; reads wait while every tag slot is in use.
  always_comb begin
    w_p0_elig  = bus.p0_en & w_own0 & (is_write_cmd(bus.p0_cmd) | ~w_fifo_full);
    w_p1_elig  = bus.p1_en & w_own1 & (is_write_cmd(bus.p1_cmd) | ~w_fifo_full);
    w_any_elig = w_p0_elig | w_p1_elig;
    if (w_p0_elig && w_p1_elig) begin
      w_winner = r_ptr;
    end else if (w_p1_elig) begin
      w_winner = 1'b1;
    end else begin
      w_winner = 1'b0;
    end
  end

  // Command mux from the granted port's live inputs.
  always_comb begin
    if (r_grant) begin
      w_sel_cmd   = bus.p1_cmd;
      w_sel_addr  = bus.p1_addr;
      w_sel_wdata = bus.p1_wdata;
      w_sel_wmask = bus.p1_wmask;
    end else begin
      w_sel_cmd   = bus.p0_cmd;
      w_sel_addr  = bus.p0_addr;
      w_sel_wdata = bus.p0_wdata;
      w_sel_wmask = bus.p0_wmask;
    end
  end

  assign w_sel_write = is_write_cmd(w_sel_cmd);
  assign w_issue     = (r_state == ARB_S_ISSUE);
  assign w_accept    = w_issue & bus.app_rdy & (~w_sel_write | bus.app_wdf_rdy);
  assign w_push      = w_accept & ~w_sel_write;
  assign w_pop       = bus.app_rd_data_valid;

  assign bus.app_en       = w_issue;
  assign bus.app_addr     = w_sel_addr;
  assign bus.app_cmd      = w_sel_write ? MEM_CMD_WRITE : MEM_CMD_READ;
  assign bus.app_wdf_data = w_sel_wdata;
  assign bus.app_wdf_mask = w_sel_wmask;
  assign bus.app_wdf_wren = w_issue & w_sel_write;
  assign bus.app_wdf_end  = w_issue & w_sel_write;

  assign bus.p0_rdy = w_accept & ~r_grant;
  assign bus.p1_rdy = w_accept & r_grant;

  // Read data is steered by the oldest outstanding tag with no added latency.
  assign bus.p0_rd_valid = bus.app_rd_data_valid & ~w_fifo_empty & ~w_fifo_head;
  assign bus.p1_rd_valid = bus.app_rd_data_valid & ~w_fifo_empty & w_fifo_head;
  assign bus.rd_data     = bus.app_rd_data;
  assign bus.grant       = r_grant;
  assign bus.err_orphan  = r_err_orphan;

  mem_arb_tag_fifo #(
    .DEPTH (OUTST)
  ) u_tag_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .i_push  (w_push),
    .i_din   (r_grant),
    .i_pop   (w_pop),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_head  (w_fifo_head)
  );

  // Arbitration FSM: pick in ARB, hold the grant through ISSUE until accepted.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= ARB_S_ARB;
      r_grant <= 1'b0;
      r_ptr   <= 1'b0;
    end else begin
      case (r_state)
        ARB_S_ARB: begin
          if (w_any_elig) begin
            r_grant <= w_winner;
            r_state <= ARB_S_ISSUE;
          end
        end
        ARB_S_ISSUE: begin
          if (w_accept) begin
            r_ptr   <= ~r_grant;
            r_state <= ARB_S_ARB;
          end
        end
        default: begin
          r_state <= ARB_S_ARB;
        end
      endcase
    end
  end

  // Sticky flag for read data that no outstanding read can own.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_err_orphan <= 1'b0;
    end else if (bus.app_rd_data_valid && w_fifo_empty) begin
      r_err_orphan <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mem_bus_arb.sv
// Randomized bench for mem_bus_arb: queue-based reference model checked every cycle, plus directed scenarios.
module tb_mem_bus_arb;
  localparam int AW    = 28;
  localparam int DW    = 128;
  localparam int MW    = DW / 8;
  localparam int OUTST = 4;

  logic clk = 1'b0;
  logic resetn = 1'b0;
`ifdef MEM_ARB_LOCK_EN
  logic bus_owner = 1'b0;
`endif

  mem_bus_arb_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_bus_arb #(.ADDR_W(AW), .DATA_W(DW), .OUTST(OUTST)) dut (
    .clk       (clk),
    .resetn    (resetn),
`ifdef MEM_ARB_LOCK_EN
    .bus_owner (bus_owner),
`endif
    .bus       (bus)
  );

  initial forever #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Reference model: issuing flag, granted port, preferred port, sticky error, outstanding read tags.
  bit m_busy = 1'b0;
  bit m_gnt  = 1'b0;
  bit m_ptr  = 1'b0;
  bit m_err  = 1'b0;
  int m_q[$];
  bit seen_rdy0 = 1'b0;
  bit seen_rdy1 = 1'b0;

  bit         c_sel, c_wr, c_acc, c_e0, c_e1, c_own0, c_own1, c_rv0, c_rv1;
  logic [2:0] c_cmd;
  int         c_qs, c_head;
  logic [DW-1:0] pat;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkw(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkn(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, then advance the model to the next cycle.
  initial forever begin
    @(negedge clk);
    c_sel  = m_gnt;
    c_cmd  = c_sel ? bus.p1_cmd : bus.p0_cmd;
    c_wr   = (c_cmd == 3'd0);
    c_acc  = m_busy && bus.app_rdy && (!c_wr || bus.app_wdf_rdy);
    c_qs   = m_q.size();
    c_head = 0;
    if (c_qs > 0) c_head = m_q[0];
    c_rv0  = bus.app_rd_data_valid && (c_qs > 0) && (c_head == 0);
    c_rv1  = bus.app_rd_data_valid && (c_qs > 0) && (c_head == 1);
    if (chk_en) begin
      chk1("grant", bus.grant, m_gnt);
      chk1("app_en", bus.app_en, m_busy);
      chkw("app_addr", 128'(bus.app_addr), 128'(c_sel ? bus.p1_addr : bus.p0_addr));
      chkw("app_wdf_data", bus.app_wdf_data, c_sel ? bus.p1_wdata : bus.p0_wdata);
      chkw("app_wdf_mask", 128'(bus.app_wdf_mask), 128'(c_sel ? bus.p1_wmask : bus.p0_wmask));
      chkw("app_cmd", 128'(bus.app_cmd), c_wr ? 128'd0 : 128'd1);
      chk1("app_wdf_wren", bus.app_wdf_wren, m_busy && c_wr);
      chk1("app_wdf_end", bus.app_wdf_end, m_busy && c_wr);
      chk1("p0_rdy", bus.p0_rdy, c_acc && !c_sel);
      chk1("p1_rdy", bus.p1_rdy, c_acc && c_sel);
      chk1("p0_rd_valid", bus.p0_rd_valid, c_rv0);
      chk1("p1_rd_valid", bus.p1_rd_valid, c_rv1);
      chkw("rd_data", bus.rd_data, bus.app_rd_data);
      chk1("err_orphan", bus.err_orphan, m_err);
    end
    seen_rdy0 = bus.p0_rdy;
    seen_rdy1 = bus.p1_rdy;
    if (!resetn) begin
      m_busy = 1'b0; m_gnt = 1'b0; m_ptr = 1'b0; m_err = 1'b0;
      m_q.delete();
    end else begin
      if (bus.app_rd_data_valid) begin
        if (c_qs == 0) m_err = 1'b1;
        else void'(m_q.pop_front());
      end
      if (m_busy) begin
        if (c_acc) begin
          if (!c_wr) m_q.push_back(int'(c_sel));
          m_ptr  = !c_sel;
          m_busy = 1'b0;
        end
      end else begin
`ifdef MEM_ARB_LOCK_EN
        c_own0 = !bus_owner;
        c_own1 = bus_owner;
`else
        c_own0 = 1'b1;
        c_own1 = 1'b1;
`endif
        c_e0 = bus.p0_en && c_own0 && ((bus.p0_cmd == 3'd0) || (c_qs < OUTST));
        c_e1 = bus.p1_en && c_own1 && ((bus.p1_cmd == 3'd0) || (c_qs < OUTST));
        if (c_e0 || c_e1) begin
          m_busy = 1'b1;
          m_gnt  = (c_e0 && c_e1) ? m_ptr : c_e1;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic idle_inputs();
    bus.p0_en = 1'b0; bus.p0_cmd = 3'd0; bus.p0_addr = '0; bus.p0_wdata = '0; bus.p0_wmask = '0;
    bus.p1_en = 1'b0; bus.p1_cmd = 3'd0; bus.p1_addr = '0; bus.p1_wdata = '0; bus.p1_wmask = '0;
    bus.app_rdy = 1'b0; bus.app_wdf_rdy = 1'b0; bus.app_rd_data = '0; bus.app_rd_data_valid = 1'b0;
  endtask

  task automatic new_req(input int p, input logic [2:0] cmd, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [MW-1:0] m);
    if (p == 0) begin
      bus.p0_en = 1'b1; bus.p0_cmd = cmd; bus.p0_addr = a; bus.p0_wdata = d; bus.p0_wmask = m;
    end else begin
      bus.p1_en = 1'b1; bus.p1_cmd = cmd; bus.p1_addr = a; bus.p1_wdata = d; bus.p1_wmask = m;
    end
  endtask

  // Reset for one sampled edge; returns just after the edge with resetn released (cycle 0).
  task automatic do_reset();
    step();
    idle_inputs();
    resetn = 1'b0;
    step();
    resetn = 1'b1;
  endtask

  task automatic drive_port(input int p);
    logic en, rdy;
    en  = (p == 0) ? bus.p0_en : bus.p1_en;
    rdy = (p == 0) ? seen_rdy0 : seen_rdy1;
    if (!en || rdy) begin
      if (($urandom % 2) == 0)
        new_req(p, (($urandom % 5) < 2) ? 3'd0 : 3'($urandom), AW'($urandom), rnd128(), MW'($urandom));
      else if (p == 0) bus.p0_en = 1'b0;
      else bus.p1_en = 1'b0;
    end
  endtask

  bit g[$];
  int n0, n1;
  bit got0, got1, bad0;

  initial begin
    idle_inputs();
    pat = {16{8'hA5}};
    resetn = 1'b0;
    repeat (3) step();
    chk_en = 1'b1;

    // Reset state.
    @(negedge clk);
    chk1("rst_grant", bus.grant, 1'b0);
    chk1("rst_app_en", bus.app_en, 1'b0);
    chk1("rst_wren", bus.app_wdf_wren, 1'b0);
    chk1("rst_p0_rdy", bus.p0_rdy, 1'b0);
    chk1("rst_p1_rdy", bus.p1_rdy, 1'b0);
    chk1("rst_err", bus.err_orphan, 1'b0);

    // Single port 0 write.
    step();
    resetn = 1'b1;
    new_req(0, 3'd0, 28'h0000010, pat, 16'hFFFF);
    bus.app_rdy = 1'b1; bus.app_wdf_rdy = 1'b1;
    @(negedge clk);
    chk1("t1_c0_app_en", bus.app_en, 1'b0);
    step(); @(negedge clk);
    chk1("t1_c1_app_en", bus.app_en, 1'b1);
    chk1("t1_c1_p0_rdy", bus.p0_rdy, 1'b1);
    chk1("t1_c1_wren", bus.app_wdf_wren, 1'b1);
    chkw("t1_c1_addr", 128'(bus.app_addr), 128'h10);
    chkw("t1_c1_data", bus.app_wdf_data, pat);
    chkw("t1_c1_mask", 128'(bus.app_wdf_mask), 128'hFFFF);
    step(); bus.p0_en = 1'b0;
    @(negedge clk);
    chk1("t1_c2_app_en", bus.app_en, 1'b0);

    // Both ports reading continuously: grants alternate, data returns in issue order.
    do_reset();
    new_req(0, 3'd1, 28'h100, '0, '0);
    new_req(1, 3'd1, 28'h200, '0, '0);
    bus.app_rdy = 1'b1; bus.app_wdf_rdy = 1'b1;
    g.delete();
    for (int i = 0; i < 20 && g.size() < 4; i++) begin
      @(negedge clk);
      if (bus.p0_rdy) g.push_back(1'b0);
      if (bus.p1_rdy) g.push_back(1'b1);
      step();
    end
    bus.p0_en = 1'b0; bus.p1_en = 1'b0;
    chkn("t2_accepts", g.size(), 4);
    for (int i = 0; i < g.size(); i++) chkn("t2_grant_order", int'(g[i]), i % 2);
    for (int i = 0; i < 4; i++) begin
      bus.app_rd_data_valid = 1'b1;
      bus.app_rd_data = rnd128();
      @(negedge clk);
      chk1("t2_p0_rd_valid", bus.p0_rd_valid, (i % 2) == 0);
      chk1("t2_p1_rd_valid", bus.p1_rd_valid, (i % 2) == 1);
      step();
    end
    bus.app_rd_data_valid = 1'b0;

    // Controller back-pressure during a port 1 read.
    do_reset();
    new_req(1, 3'd1, 28'h300, '0, '0);
    bus.app_rdy = 1'b0; bus.app_wdf_rdy = 1'b1;
    @(negedge clk);
    chk1("t3_c0_app_en", bus.app_en, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      step(); @(negedge clk);
      chk1("t3_stall_app_en", bus.app_en, 1'b1);
      chk1("t3_stall_grant", bus.grant, 1'b1);
      chk1("t3_stall_p1_rdy", bus.p1_rdy, 1'b0);
    end
    step(); bus.app_rdy = 1'b1;
    @(negedge clk);
    chk1("t3_c6_p1_rdy", bus.p1_rdy, 1'b1);
    step(); bus.p1_en = 1'b0;

    // Full tag FIFO: writes proceed, reads wait for a response.
    do_reset();
    new_req(0, 3'd1, 28'h400, '0, '0);
    bus.app_rdy = 1'b1; bus.app_wdf_rdy = 1'b1;
    n0 = 0;
    for (int i = 0; i < 30 && n0 < 4; i++) begin
      @(negedge clk);
      if (bus.p0_rdy) n0++;
      step();
    end
    chkn("t4_fill", n0, 4);
    new_req(1, 3'd0, 28'h500, rnd128(), 16'h00FF);
    got1 = 1'b0; bad0 = 1'b0;
    for (int i = 0; i < 10 && !got1; i++) begin
      @(negedge clk);
      if (bus.p1_rdy) got1 = 1'b1;
      if (bus.p0_rdy) bad0 = 1'b1;
      step();
    end
    bus.p1_en = 1'b0;
    chk1("t4_write_issued", got1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.p0_rdy) bad0 = 1'b1;
      step();
    end
    chk1("t4_read_stalled", bad0, 1'b0);
    bus.app_rd_data_valid = 1'b1;
    @(negedge clk);
    chk1("t4_pop_p0_rd_valid", bus.p0_rd_valid, 1'b1);
    step();
    bus.app_rd_data_valid = 1'b0;
    got0 = 1'b0;
    for (int i = 0; i < 6 && !got0; i++) begin
      @(negedge clk);
      if (bus.p0_rdy) got0 = 1'b1;
      step();
    end
    bus.p0_en = 1'b0;
    chk1("t4_read_after_pop", got0, 1'b1);

    // Orphan read data.
    do_reset();
    bus.app_rd_data_valid = 1'b1;
    @(negedge clk);
    chk1("t5_p0_rd_valid", bus.p0_rd_valid, 1'b0);
    chk1("t5_p1_rd_valid", bus.p1_rd_valid, 1'b0);
    step(); bus.app_rd_data_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk1("t5_err_sticky", bus.err_orphan, 1'b1);
      step();
    end
    resetn = 1'b0;
    step(); resetn = 1'b1;
    @(negedge clk);
    chk1("t5_err_cleared", bus.err_orphan, 1'b0);

`ifdef MEM_ARB_LOCK_EN
    // Bus ownership lock.
    do_reset();
    bus_owner = 1'b0;
    new_req(0, 3'd0, 28'h600, rnd128(), 16'hFFFF);
    new_req(1, 3'd0, 28'h700, rnd128(), 16'hFFFF);
    bus.app_rdy = 1'b1; bus.app_wdf_rdy = 1'b1;
    n0 = 0; n1 = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.p0_rdy) n0++;
      if (bus.p1_rdy) n1++;
      step();
    end
    chkn("t6_owner0_p0", n0, 6);
    chkn("t6_owner0_p1", n1, 0);
    bus_owner = 1'b1;
    n0 = 0; n1 = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.p0_rdy) n0++;
      if (bus.p1_rdy) n1++;
      step();
    end
    chkn("t6_owner1_p0", n0, 0);
    chkn("t6_owner1_p1", n1, 6);
`endif

    // Randomized traffic against the reference model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      drive_port(0);
      drive_port(1);
      bus.app_rdy = ($urandom % 4) != 0;
      bus.app_wdf_rdy = ($urandom % 5) != 0;
      bus.app_rd_data_valid = ((m_q.size() > 0) && (($urandom % 3) == 0)) || (($urandom % 300) == 0);
      bus.app_rd_data = rnd128();
      resetn = ($urandom % 300) != 0;
`ifdef MEM_ARB_LOCK_EN
      if (($urandom % 40) == 0) bus_owner = ~bus_owner;
`endif
      step();
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
